// File: rtl/pacman_pkg.sv
// Types and scoring constants shared by the game blocks (scheduler, color_mapper, game_logic).
package pacman_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, SETTLE} state_t;
  typedef enum logic [1:0] {SRC_DOT, SRC_FRUIT, SRC_GHOST, SRC_DEATH} src_t;

  localparam int PTS_DOT    = 1;
  localparam int PTS_FRUIT  = 10;
  localparam int PTS_GHOST  = 20;
  localparam int SCORE_CEIL = 999;

  // Sum is formed one bit wider than the score so the ceiling compare cannot wrap.
  function automatic logic [9:0] sat_add(input logic [9:0] s, input int pts, input int ceil);
    logic [10:0] sum;
    sum = {1'b0, s} + 11'(pts);
    return (sum > 11'(ceil)) ? 10'(ceil) : sum[9:0];
  endfunction

endpackage

// File: rtl/event_pending_counter.sv
// Saturating up/down count of not-yet-granted events from one source.
module event_pending_counter
  import pacman_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // inc and dec together leave the count alone; extra incs at max are dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_ONE;
    else if (dec && !inc && cnt_q != '0)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/score_event_scheduler.sv
// Serialises dot/fruit/ghost/death events into read-modify-write cycles on the
// score, fruit and lives registers, one write in flight at a time.
module score_event_scheduler
  import pacman_pkg::*;
#(
  parameter int DOT_PTS   = PTS_DOT,
  parameter int FRUIT_PTS = PTS_FRUIT,
  parameter int GHOST_PTS = PTS_GHOST,
  parameter int SCORE_MAX = SCORE_CEIL,
  parameter int CNT_W     = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       dot_req,
  input  logic       fruit_req,
  input  logic       ghost_req,
  input  logic       death_req,
  input  logic       pause,
  input  logic [9:0] score_from_reg,
  input  logic [3:0] fruits_from_reg,
  input  logic [7:0] lives_from_reg,
  output logic       Load_S,
  output logic [9:0] score_to_reg,
  output logic       Load_F,
  output logic [3:0] fruits_to_reg,
  output logic       Load_L,
  output logic [7:0] lives_to_reg,
  output logic       busy,
  output logic       game_over
);

  state_t     state_q, state_d;
  src_t       sel_q, sel_d;
  logic       load_s_q, load_s_d, load_f_q, load_f_d, load_l_q, load_l_d;
  logic       game_over_q, game_over_d;
  logic [9:0] score_q, score_d;
  logic [3:0] fruits_q, fruits_d;
  logic [7:0] lives_q, lives_d;
  logic [3:0] req, dec, nz;

  assign req = {death_req, ghost_req, fruit_req, dot_req};

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    event_pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (Clk),
      .reset  (Reset),
      .inc    (req[i]),
      .dec    (dec[i]),
      .nonzero(nz[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dec         = '0;
    load_s_d    = 1'b0;
    load_f_d    = 1'b0;
    load_l_d    = 1'b0;
    game_over_d = 1'b0;
    score_d     = score_q;
    fruits_d    = fruits_q;
    lives_d     = lives_q;
    case (state_q)
      IDLE: begin
        if (|nz && !pause) begin
          state_d = GRANT;
          if (nz[SRC_DEATH])      begin sel_d = SRC_DEATH; dec[SRC_DEATH] = 1'b1; end
          else if (nz[SRC_GHOST]) begin sel_d = SRC_GHOST; dec[SRC_GHOST] = 1'b1; end
          else if (nz[SRC_FRUIT]) begin sel_d = SRC_FRUIT; dec[SRC_FRUIT] = 1'b1; end
          else                    begin sel_d = SRC_DOT;   dec[SRC_DOT]   = 1'b1; end
        end
      end
      GRANT: begin
        state_d = WRITE;
        case (sel_q)
          SRC_DOT: begin
            score_d  = sat_add(score_from_reg, DOT_PTS, SCORE_MAX);
            load_s_d = 1'b1;
          end
          SRC_GHOST: begin
            score_d  = sat_add(score_from_reg, GHOST_PTS, SCORE_MAX);
            load_s_d = 1'b1;
          end
          SRC_FRUIT: begin
            if (fruits_from_reg != 4'd0) begin
              score_d  = sat_add(score_from_reg, FRUIT_PTS, SCORE_MAX);
              fruits_d = fruits_from_reg - 4'd1;
              load_s_d = 1'b1;
              load_f_d = 1'b1;
            end else begin
              state_d = SETTLE;
            end
          end
          default: begin
            if (lives_from_reg != 8'd0) begin
              lives_d     = lives_from_reg - 8'd1;
              load_l_d    = 1'b1;
              game_over_d = (lives_from_reg == 8'd1);
            end else begin
              state_d = SETTLE;
            end
          end
        endcase
      end
      WRITE:   state_d = SETTLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are set on the GRANT->WRITE edge, so they are high for the WRITE cycle only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      sel_q       <= SRC_DOT;
      load_s_q    <= 1'b0;
      load_f_q    <= 1'b0;
      load_l_q    <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= '0;
      fruits_q    <= '0;
      lives_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      load_s_q    <= load_s_d;
      load_f_q    <= load_f_d;
      load_l_q    <= load_l_d;
      game_over_q <= game_over_d;
      score_q     <= score_d;
      fruits_q    <= fruits_d;
      lives_q     <= lives_d;
    end
  end

  assign Load_S        = load_s_q;
  assign Load_F        = load_f_q;
  assign Load_L        = load_l_q;
  assign game_over     = game_over_q;
  assign score_to_reg  = score_q;
  assign fruits_to_reg = fruits_q;
  assign lives_to_reg  = lives_q;
  assign busy          = (state_q != IDLE) | (|nz);

endmodule

// File: tb/tb_score_event_scheduler.sv
// Directed bench for score_event_scheduler with a behavioural model of the three target registers.
module tb_score_event_scheduler;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       dot_req = 1'b0, fruit_req = 1'b0, ghost_req = 1'b0, death_req = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] score_r = '0;
  logic [3:0] fruits_r = '0;
  logic [7:0] lives_r = '0;
  logic       Load_S, Load_F, Load_L, busy, game_over;
  logic [9:0] score_to_reg;
  logic [3:0] fruits_to_reg;
  logic [7:0] lives_to_reg;

  logic       wr_en = 1'b0;
  logic [9:0] set_score = '0;
  logic [3:0] set_fruits = '0;
  logic [7:0] set_lives = '0;

  int total = 0;
  int bad = 0;

  score_event_scheduler dut (
    .Clk(Clk), .Reset(Reset),
    .dot_req(dot_req), .fruit_req(fruit_req), .ghost_req(ghost_req), .death_req(death_req),
    .pause(pause),
    .score_from_reg(score_r), .fruits_from_reg(fruits_r), .lives_from_reg(lives_r),
    .Load_S(Load_S), .score_to_reg(score_to_reg),
    .Load_F(Load_F), .fruits_to_reg(fruits_to_reg),
    .Load_L(Load_L), .lives_to_reg(lives_to_reg),
    .busy(busy), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  // Target registers: loaded by the bench for setup, otherwise by the DUT strobes.
  always @(posedge Clk) begin
    if (wr_en) begin
      score_r  <= set_score;
      fruits_r <= set_fruits;
      lives_r  <= set_lives;
    end else begin
      if (Load_S) score_r  <= score_to_reg;
      if (Load_F) fruits_r <= fruits_to_reg;
      if (Load_L) lives_r  <= lives_to_reg;
    end
  end

  logic [25:0] obs;
  assign obs = {Load_S, Load_F, Load_L, game_over, score_to_reg, fruits_to_reg, lives_to_reg};

  typedef struct {
    logic [3:0] req;   // {death, ghost, fruit, dot}
    logic [9:0] sc;
    logic [3:0] fr;
    logic [7:0] lv;
    logic       s, f, l, go;
    logic [9:0] w_sc;
    logic [3:0] w_fr;
    logic [7:0] w_lv;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [25:0] got, input logic [25:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] s, input logic [3:0] f, input logic [7:0] l);
    set_score = s; set_fruits = f; set_lives = l;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    {death_req, ghost_req, fruit_req, dot_req} = m;
    tick();
    {death_req, ghost_req, fruit_req, dot_req} = 4'b0000;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check(name, {25'd0, busy}, 26'd0);
  endtask

  task automatic check_masked(input string name, input logic s, input logic f, input logic l,
                              input logic go, input logic [9:0] sc, input logic [3:0] fr,
                              input logic [7:0] lv);
    logic [25:0] mask, want;
    mask = {4'hf, {10{s}}, {4{f}}, {8{l}}};
    want = {s, f, l, go, sc, fr, lv};
    check(name, obs & mask, want & mask);
  endtask

  initial begin
    int n;
    vecs[0]  = '{4'b0001, 10'd0,   4'd4, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1,   4'd0, 8'd0};
    vecs[1]  = '{4'b0100, 10'd995, 4'd4, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10'd999, 4'd0, 8'd0};
    vecs[2]  = '{4'b0001, 10'd999, 4'd4, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10'd999, 4'd0, 8'd0};
    vecs[3]  = '{4'b0010, 10'd500, 4'd0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   4'd0, 8'd0};
    vecs[4]  = '{4'b1000, 10'd500, 4'd2, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0,   4'd0, 8'd0};
    vecs[5]  = '{4'b1000, 10'd500, 4'd2, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   4'd0, 8'd0};
    vecs[6]  = '{4'b0010, 10'd100, 4'd5, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 10'd110, 4'd4, 8'd0};
    vecs[7]  = '{4'b1000, 10'd100, 4'd5, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   4'd0, 8'd2};
    vecs[8]  = '{4'b0001, 10'd998, 4'd5, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10'd999, 4'd0, 8'd0};
    vecs[9]  = '{4'b0100, 10'd985, 4'd5, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10'd999, 4'd0, 8'd0};
    vecs[10] = '{4'b0100, 10'd979, 4'd5, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 10'd999, 4'd0, 8'd0};
    vecs[11] = '{4'b0010, 10'd995, 4'd1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 10'd999, 4'd0, 8'd0};

    // Reset state
    tick(); tick();
    check("reset_hold", {obs[25:1], busy}, 26'd0);
    Reset = 1'b0;
    tick();
    check("reset_release", {obs[25:1], busy}, 26'd0);

    // Single events: nothing in GRANT, strobes in the third cycle after the pulse, then quiet
    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].sc, vecs[i].fr, vecs[i].lv);
      pulse(vecs[i].req);
      tick();
      check($sformatf("vec%0d_pre", i), {22'd0, obs[25:22]}, 26'd0);
      tick();
      check_masked($sformatf("vec%0d_write", i), vecs[i].s, vecs[i].f, vecs[i].l, vecs[i].go,
                   vecs[i].w_sc, vecs[i].w_fr, vecs[i].w_lv);
      tick();
      check($sformatf("vec%0d_post", i), {22'd0, obs[25:22]}, 26'd0);
      wait_idle($sformatf("vec%0d_idle", i));
    end

    // Simultaneous events: death, ghost, fruit, dot with WRITEs 4 cycles apart
    preload(10'd0, 4'd4, 8'd3);
    pulse(4'b1111);
    for (int c = 2; c <= 16; c++) begin
      tick();
      case (c)
        3:       check_masked("all4_death", 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 4'd0, 8'd2);
        7:       check_masked("all4_ghost", 1'b1, 1'b0, 1'b0, 1'b0, 10'd20, 4'd0, 8'd0);
        11:      check_masked("all4_fruit", 1'b1, 1'b1, 1'b0, 1'b0, 10'd30, 4'd3, 8'd0);
        15:      check_masked("all4_dot",   1'b1, 1'b0, 1'b0, 1'b0, 10'd31, 4'd0, 8'd0);
        default: check($sformatf("all4_quiet_c%0d", c), {22'd0, obs[25:22]}, 26'd0);
      endcase
    end
    wait_idle("all4_idle");

    // Pause: five dot pulses saturate the counter at 3
    preload(10'd50, 4'd4, 8'd3);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) pulse(4'b0001);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n += int'(Load_S) + int'(Load_F) + int'(Load_L);
    end
    check("pause_no_loads", 26'(n), 26'd0);
    check("pause_busy", {25'd0, busy}, 26'd1);
    pause = 1'b0;
    n = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      n += int'(Load_S);
    end
    check("pause_release_writes", 26'(n), 26'd3);
    check("pause_release_score", {16'd0, score_r}, 26'd53);
    wait_idle("pause_idle");

    // Reset during WRITE aborts everything pending
    preload(10'd0, 4'd4, 8'd3);
    pulse(4'b0101);
    tick();
    tick();
    check_masked("rst_write", 1'b1, 1'b0, 1'b0, 1'b0, 10'd20, 4'd0, 8'd0);
    Reset = 1'b1;
    tick();
    check("rst_abort", {21'd0, obs[25:22], busy}, 26'd0);
    Reset = 1'b0;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      n += int'(Load_S) + int'(Load_F) + int'(Load_L) + int'(busy);
    end
    check("rst_no_further", 26'(n), 26'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
